acc_alu_stage: RTL and testbench
================================

# acc_alu_stage

Accumulator-based execute stage that sits directly downstream of the 8-bit operand select mux (`mux2x1`). It consumes the mux output as its operand, applies a 3-bit opcode against an internal accumulator, and publishes the result with zero/carry flags. A valid/ready handshake throttles the upstream stage while a multi-cycle multiply is in progress.

## Interface
- `WIDTH`, default 8: operand and accumulator width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand/opcode presented.
- `in_ready` output 1: stage can accept; transfer when `in_valid && in_ready` at a rising edge.
- `op` input 3: opcode, sampled on transfer.
- `operand` input WIDTH: mux output, sampled on transfer.
- `acc_out` output WIDTH: accumulator, registered.
- `zero` output 1: `acc_out == 0`, registered with each update.
- `carry` output 1: carry/borrow flag, registered.
- `out_valid` output 1: one-cycle pulse when a new result is on `acc_out`.
- `busy` output 1: high while a multiply is iterating.

## Operation
- Opcodes:
  - 000 LOAD: acc = operand; carry = 0.
  - 001 ADD: {carry, acc} = acc + operand.
  - 010 SUB: acc = acc − operand mod 2^WIDTH; carry = 1 iff operand > acc (borrow).
  - 011 AND, 100 OR, 101 XOR: bitwise with operand; carry = 0.
  - 110 SHL: acc = acc << 1; carry = old acc[WIDTH-1]; operand is ignored.
  - 111 MUL: see Configuration.
- `zero` is recomputed from the new acc on every update.
- FSM states:
  - IDLE: `in_ready` = 1.
    - Transfer of a non-MUL opcode: update acc and flags at that edge, stay in IDLE.
    - Transfer of MUL: latch the multiplier (operand) and the multiplicand (acc), clear the 2·WIDTH product, set count = WIDTH, go to MUL.
  - MUL: `in_ready` = 0, `busy` = 1.
    - Each cycle performs one shift-add step and decrements count.
    - At the edge where count reaches 0: acc = product[WIDTH-1:0]; carry = |product[2·WIDTH-1:WIDTH]; go to IDLE.
- Reset (any state, including mid-MUL) aborts the operation and discards the partial product.
- Reset values:
  - `acc_out` = 0.
  - `zero` = 1.
  - `carry` = 0.
  - `out_valid` = 0.
  - `busy` = 0.
  - `in_ready` = 1 from the first cycle after reset, with the FSM in IDLE.
- Inputs are ignored whenever `in_ready` = 0.

## Timing
- Non-MUL ops:
  - Result appears on `acc_out` in the cycle after the transfer edge.
  - `out_valid` is high for exactly that cycle.
  - Back-to-back transfers are allowed every cycle; each result is visible one cycle later.
- MUL:
  - Transfer at edge E0.
  - Iteration steps at edges E1..E(WIDTH); the result is written at E(WIDTH).
  - `out_valid` = 1 and `in_ready` = 1 in the cycle after E(WIDTH): 8 cycles after transfer for WIDTH = 8.
  - `busy` is high in the cycles between E0 and E(WIDTH).
- `out_valid` has no backpressure: the consumer must sample it on the pulse.
- Reset asserted in the same cycle as `in_valid`: reset wins, the transfer is dropped, and `out_valid` stays 0.

## Configuration
- `ACC_ALU_MUL_EN` defined: opcode 111 is an iterative shift-add multiply as described above. The FSM includes the MUL state and `busy` can assert.
- `ACC_ALU_MUL_EN` undefined: opcode 111 is a NOP.
  - acc and flags are unchanged.
  - `out_valid` still pulses in the next cycle.
  - The MUL state and product datapath are not compiled; `busy` is tied to 0 and `in_ready` is tied to 1.

## Test plan
- Reset check: assert `rst` for 2 cycles with `in_valid` = 1, `op` = LOAD, `operand` = 0x55 → after release, `acc_out` = 0x00, `zero` = 1, `carry` = 0, no `out_valid` pulse.
- Back-to-back ALU ops: LOAD 0x01, ADD 0x01, ADD 0xFF, SHL on consecutive cycles →
  - `acc_out` sequence 0x01, 0x02, 0x01, 0x02.
  - `carry` sequence 0, 0, 1, 0.
  - `out_valid` high for 4 consecutive cycles.
- Borrow and zero: LOAD 0x03, SUB 0x05 → `acc_out` = 0xFE, `carry` = 1. Then SUB 0xFE → `acc_out` = 0x00, `zero` = 1, `carry` = 0.
- MUL (macro defined): LOAD 0x12, MUL 0x10 →
  - `in_ready` = 0 and `busy` = 1 for the cycles between transfer and result.
  - `out_valid` 8 cycles after the transfer edge with `acc_out` = 0x20, `carry` = 1.
  - `in_valid` held high with `op` = ADD during `busy` is not accepted.
- Reset mid-MUL: start MUL 0x03 on acc 0x05, assert `rst` on the 4th busy cycle → `acc_out` = 0, `busy` = 0, `in_ready` = 1 next cycle, no `out_valid`.
- Macro undefined: LOAD 0x07, then `op` = 111 with `operand` = 0x09 → `acc_out` stays 0x07, flags unchanged, `out_valid` pulses 1 cycle later, `in_ready` never drops.

Source files
------------

// File: rtl/acc_alu_stage.sv
// Accumulator execute stage: 3-bit opcode ALU against an internal accumulator with zero/carry flags.
// Define ACC_ALU_MUL_EN to build opcode 111 as an iterative shift-add multiply; otherwise it is a NOP.
module acc_alu_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_out,
    output logic             zero,
    output logic             carry,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_s;
    logic             busy_s;
    logic             xfer_s;
    logic [WIDTH:0]   add_sum_s;

`ifdef ACC_ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [CNT_W-1:0]   count_q, count_d;

    assign busy_s     = (state_q == ST_MUL);
    assign in_ready_s = (state_q == ST_IDLE);
`else
    assign busy_s     = 1'b0;
    assign in_ready_s = 1'b1;
`endif

    assign xfer_s    = in_valid && in_ready_s;
    assign add_sum_s = {1'b0, acc_q} + {1'b0, operand};

    // Next-state: ALU result on transfer, or one multiply step while iterating.
    always_comb begin
        acc_d       = acc_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
`ifdef ACC_ALU_MUL_EN
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        product_d   = product_q;
        count_d     = count_q;
`endif
        if (xfer_s) begin
            out_valid_d = 1'b1;
            case (op)
                OP_LOAD: begin
                    acc_d   = operand;
                    carry_d = 1'b0;
                end
                OP_ADD: begin
                    acc_d   = add_sum_s[WIDTH-1:0];
                    carry_d = add_sum_s[WIDTH];
                end
                OP_SUB: begin
                    acc_d   = acc_q - operand;
                    carry_d = (operand > acc_q);
                end
                OP_AND: begin
                    acc_d   = acc_q & operand;
                    carry_d = 1'b0;
                end
                OP_OR: begin
                    acc_d   = acc_q | operand;
                    carry_d = 1'b0;
                end
                OP_XOR: begin
                    acc_d   = acc_q ^ operand;
                    carry_d = 1'b0;
                end
                OP_SHL: begin
                    acc_d   = {acc_q[WIDTH-2:0], 1'b0};
                    carry_d = acc_q[WIDTH-1];
                end
                OP_MUL: begin
`ifdef ACC_ALU_MUL_EN
                    // Result is published only when the iteration completes.
                    out_valid_d = 1'b0;
                    state_d     = ST_MUL;
                    mcand_d     = {{WIDTH{1'b0}}, acc_q};
                    mplier_d    = operand;
                    product_d   = {(2*WIDTH){1'b0}};
                    count_d     = CNT_W'(WIDTH);
`else
                    acc_d   = acc_q;
                    carry_d = carry_q;
`endif
                end
                default: begin
                    acc_d   = acc_q;
                    carry_d = carry_q;
                end
            endcase
        end
`ifdef ACC_ALU_MUL_EN
        else if (state_q == ST_MUL) begin
            product_d = product_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
            mcand_d   = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d  = {1'b0, mplier_q[WIDTH-1:1]};
            count_d   = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
                acc_d       = product_d[WIDTH-1:0];
                carry_d     = |product_d[2*WIDTH-1:WIDTH];
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end else begin
                state_d = ST_MUL;
            end
        end
`endif
        else begin
            out_valid_d = 1'b0;
        end
        zero_d = (acc_d == {WIDTH{1'b0}});
    end

    // State registers with synchronous reset that also aborts a multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= {WIDTH{1'b0}};
            zero_q      <= 1'b1;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ACC_ALU_MUL_EN
            state_q     <= ST_IDLE;
            mcand_q     <= {(2*WIDTH){1'b0}};
            mplier_q    <= {WIDTH{1'b0}};
            product_q   <= {(2*WIDTH){1'b0}};
            count_q     <= {CNT_W{1'b0}};
`endif
        end else begin
            acc_q       <= acc_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
`ifdef ACC_ALU_MUL_EN
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            product_q   <= product_d;
            count_q     <= count_d;
`endif
        end
    end

    assign acc_out   = acc_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_s;
    assign in_ready  = in_ready_s;

endmodule

// File: tb/tb_acc_alu_stage.sv
// Directed bench for acc_alu_stage; selects the multiply or NOP scenarios from ACC_ALU_MUL_EN.
module tb_acc_alu_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] operand;
    logic [7:0] acc_out;
    logic       zero;
    logic       carry;
    logic       out_valid;
    logic       busy;

    int errors;
    int checks;

    acc_alu_stage #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .operand  (operand),
        .acc_out  (acc_out),
        .zero     (zero),
        .carry    (carry),
        .out_valid(out_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] d);
        in_valid = v;
        op       = o;
        operand  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 3'b000, 8'h55);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ov_during got %b exp 0", out_valid);
        end
        tick();
        rst = 1'b0;
        drive(1'b0, 3'b000, 8'h00);
        checks++;
        if (acc_out !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got acc=%h z=%b c=%b exp acc=00 z=1 c=0", acc_out, zero, carry);
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got rdy=%b busy=%b exp rdy=1 busy=0", in_ready, busy);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || acc_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_after got ov=%b acc=%h exp ov=0 acc=00", out_valid, acc_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [4]   = '{3'b000, 3'b001, 3'b001, 3'b110};
        logic [7:0] opnd [4]  = '{8'h01, 8'h01, 8'hFF, 8'h00};
        logic [7:0] exp_a [4] = '{8'h01, 8'h02, 8'h01, 8'h02};
        logic       exp_c [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], opnd[i]);
            tick();
            checks++;
            if (acc_out !== exp_a[i] || carry !== exp_c[i] || out_valid !== 1'b1 || zero !== 1'b0) begin
                errors++;
                $display("FAIL b2b[%0d] got acc=%h c=%b ov=%b z=%b exp acc=%h c=%b ov=1 z=0",
                         i, acc_out, carry, out_valid, zero, exp_a[i], exp_c[i]);
            end
        end
        drive(1'b0, 3'b001, 8'h33);
        tick();
        checks++;
        if (out_valid !== 1'b0 || acc_out !== 8'h02) begin
            errors++;
            $display("FAIL b2b_idle got ov=%b acc=%h exp ov=0 acc=02", out_valid, acc_out);
        end
    endtask

    task automatic test_borrow_zero();
        drive(1'b1, 3'b000, 8'h03);
        tick();
        drive(1'b1, 3'b010, 8'h05);
        tick();
        checks++;
        if (acc_out !== 8'hFE || carry !== 1'b1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow got acc=%h c=%b z=%b exp acc=fe c=1 z=0", acc_out, carry, zero);
        end
        drive(1'b1, 3'b010, 8'hFE);
        tick();
        checks++;
        if (acc_out !== 8'h00 || carry !== 1'b0 || zero !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero got acc=%h c=%b z=%b ov=%b exp acc=00 c=0 z=1 ov=1",
                     acc_out, carry, zero, out_valid);
        end
        drive(1'b0, 3'b000, 8'h00);
    endtask

    task automatic test_logic_ops();
        // LOAD F0; ADD 20 -> 110; AND 3C; OR 0F; XOR FF; SHL
        logic [2:0] ops [6]   = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110};
        logic [7:0] opnd [6]  = '{8'hF0, 8'h20, 8'h3C, 8'h0F, 8'hFF, 8'h5A};
        logic [7:0] exp_a [6] = '{8'hF0, 8'h10, 8'h10, 8'h1F, 8'hE0, 8'hC0};
        logic       exp_c [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ops[i], opnd[i]);
            tick();
            checks++;
            if (acc_out !== exp_a[i] || carry !== exp_c[i]) begin
                errors++;
                $display("FAIL logic[%0d] got acc=%h c=%b exp acc=%h c=%b",
                         i, acc_out, carry, exp_a[i], exp_c[i]);
            end
        end
        drive(1'b0, 3'b000, 8'h00);
        tick();
    endtask

`ifdef ACC_ALU_MUL_EN
    task automatic test_mul();
        drive(1'b1, 3'b000, 8'h12);
        tick();
        drive(1'b1, 3'b111, 8'h10);
        tick();
        drive(1'b1, 3'b001, 8'h01);
        for (int i = 1; i < 8; i++) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || acc_out !== 8'h12) begin
                errors++;
                $display("FAIL mul_busy[%0d] got busy=%b rdy=%b ov=%b acc=%h exp 1 0 0 12",
                         i, busy, in_ready, out_valid, acc_out);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mul_busy_last got busy=%b rdy=%b exp 1 0", busy, in_ready);
        end
        tick();
        drive(1'b0, 3'b000, 8'h00);
        checks++;
        if (out_valid !== 1'b1 || acc_out !== 8'h20 || carry !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_result got ov=%b acc=%h c=%b busy=%b rdy=%b exp 1 20 1 0 1",
                     out_valid, acc_out, carry, busy, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || acc_out !== 8'h20) begin
            errors++;
            $display("FAIL mul_after got ov=%b acc=%h exp ov=0 acc=20", out_valid, acc_out);
        end
    endtask

    task automatic test_reset_mid_mul();
        drive(1'b1, 3'b000, 8'h05);
        tick();
        drive(1'b1, 3'b111, 8'h03);
        tick();
        drive(1'b0, 3'b000, 8'h00);
        tick();
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midmul_busy got %b exp 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (acc_out !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL midmul_reset got acc=%h busy=%b rdy=%b ov=%b z=%b exp 00 0 1 0 1",
                     acc_out, busy, in_ready, out_valid, zero);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || acc_out !== 8'h00) begin
                errors++;
                $display("FAIL midmul_quiet[%0d] got ov=%b acc=%h exp ov=0 acc=00", i, out_valid, acc_out);
            end
        end
    endtask
`else
    task automatic test_nop();
        drive(1'b1, 3'b000, 8'h07);
        tick();
        drive(1'b1, 3'b111, 8'h09);
        tick();
        checks++;
        if (acc_out !== 8'h07 || zero !== 1'b0 || carry !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL nop_plain got acc=%h z=%b c=%b ov=%b rdy=%b exp 07 0 0 1 1",
                     acc_out, zero, carry, out_valid, in_ready);
        end
        drive(1'b1, 3'b000, 8'hFF);
        tick();
        drive(1'b1, 3'b001, 8'h08);
        tick();
        drive(1'b1, 3'b111, 8'h09);
        tick();
        drive(1'b0, 3'b000, 8'h00);
        checks++;
        if (acc_out !== 8'h07 || carry !== 1'b1 || out_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL nop_carry got acc=%h c=%b ov=%b busy=%b exp 07 1 1 0",
                     acc_out, carry, out_valid, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_out !== 8'h07) begin
                errors++;
                $display("FAIL nop_after[%0d] got rdy=%b ov=%b acc=%h exp 1 0 07",
                         i, in_ready, out_valid, acc_out);
            end
        end
    endtask
`endif

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 3'b000;
        operand  = 8'h00;
        test_reset();
        test_back_to_back();
        test_borrow_zero();
        test_logic_ops();
`ifdef ACC_ALU_MUL_EN
        test_mul();
        test_reset_mid_mul();
`else
        test_nop();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
